dcache_bank_arbiter: RTL

- Shares the two 512x32 data-cache SRAM banks (bank = addr[0], row = addr[9:1]) between the memory-controller cache port (fills/evictions) and core stores.
- Replaces the combinational priority mux and ad-hoc write-busy signal with three mechanisms:
  - a small in-order store queue;
  - a starvation counter;
  - a registered read-return bank select.
- Sits between Core/MemoryController and the two MemRTL dcache banks.

---
 rtl/dcache_arb_pkg.sv | 33 +++
 rtl/dcache_store_queue.sv | 82 ++++++++
 rtl/dcache_bank_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the data-cache bank arbiter.
//   DCacheAcc_t : one cache access (write flag, byte mask, word address, data)
//   arb_e       : per-cycle arbitration outcome used by the top module
//   DC_BANKS / DC_ROW_W : bank count and per-bank row address width
package dcache_arb_pkg;

  localparam int unsigned DC_BANKS = 2;
  localparam int unsigned DC_ROW_W = 9;

  typedef struct packed {
    logic        we;
    logic [3:0]  wm;
    logic [9:0]  addr;
    logic [31:0] data;
  } DCacheAcc_t;

  typedef enum logic [2:0] {
    ARB_IDLE,      // nothing granted
    ARB_MC_ONLY,   // queue empty, MC granted
    ARB_PARALLEL,  // queue head granted, MC (if valid) on the other bank
    ARB_MC_WINS,   // same bank, MC takes it, head waits
    ARB_SQ_FORCED  // same bank, head starved long enough, MC stalled
  } arb_e;

  function automatic logic acc_bank(input logic [9:0] addr);
    return addr[0];
  endfunction

  function automatic logic [DC_ROW_W-1:0] acc_row(input logic [9:0] addr);
    return addr[9:1];
  endfunction

endpackage

// File: rtl/dcache_store_queue.sv
// In-order core store queue with optional load-conflict CAM.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   enq_i, enq_data_i  enqueue request (ignored while full) and entry
//   deq_i              pop head (ignored while empty)
//   head_o             current head entry
//   empty_o, full_o    registered occupancy flags
//   ld_valid_i/ld_addr_i, ld_conflict_o  load-vs-queued-store match
// Macro DCARB_LDCONFLICT_EN enables the conflict comparators; otherwise
// ld_conflict_o is tied low.
module dcache_store_queue
  import dcache_arb_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enq_i,
  input  DCacheAcc_t  enq_data_i,
  input  logic        deq_i,
  input  logic        ld_valid_i,
  input  logic [9:0]  ld_addr_i,
  output DCacheAcc_t  head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        ld_conflict_o
);

  localparam int unsigned PTR_W = $clog2(SQ_DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  DCacheAcc_t       mem_q [SQ_DEPTH];
  logic             do_enq, do_deq;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(SQ_DEPTH));
  assign do_enq  = enq_i && !full_o;
  assign do_deq  = deq_i && !empty_o;
  assign head_o  = mem_q[head_q];

  always_comb begin
    head_d  = head_q + PTR_W'(do_deq);
    tail_d  = tail_q + PTR_W'(do_enq);
    count_d = count_q + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_deq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_enq) mem_q[tail_q] <= enq_data_i;
  end

`ifdef DCARB_LDCONFLICT_EN
  // A slot is live when its distance from the head is below the count.
  always_comb begin
    ld_conflict_o = 1'b0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (ld_valid_i
          && ((PTR_W+1)'(PTR_W'(i) - head_q) < count_q)
          && (mem_q[i].addr == ld_addr_i)
          && (|mem_q[i].wm))
        ld_conflict_o = 1'b1;
    end
  end
`else
  logic unused_ld;
  assign unused_ld     = ^{ld_valid_i, ld_addr_i};
  assign ld_conflict_o = 1'b0;
`endif

endmodule

// File: rtl/dcache_bank_arbiter.sv
// Arbitrates the two data-cache SRAM banks (bank = addr[0], row = addr[9:1])
// between the memory-controller port and queued core stores.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   IN_mc*/OUT_mcStall/OUT_mcRData  MC access request, stall, read return
//   IN_st*/OUT_stStall          core store request, queue-full stall
//   IN_ldValid/IN_ldAddr/OUT_ldConflict  load vs queued-store conflict
//   OUT_bank*/IN_bankRData      per-bank SRAM port 0 (active-low enables)
// Macro DCARB_LDCONFLICT_EN (see dcache_store_queue) enables OUT_ldConflict.
module dcache_bank_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned SQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned READ_LAT     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                IN_mcValid,
  input  logic                                IN_mcWe,
  input  logic [3:0]                          IN_mcWm,
  input  logic [9:0]                          IN_mcAddr,
  input  logic [31:0]                         IN_mcData,
  output logic                                OUT_mcStall,
  output logic [31:0]                         OUT_mcRData,
  input  logic                                IN_stValid,
  input  logic [3:0]                          IN_stWm,
  input  logic [9:0]                          IN_stAddr,
  input  logic [31:0]                         IN_stData,
  output logic                                OUT_stStall,
  input  logic                                IN_ldValid,
  input  logic [9:0]                          IN_ldAddr,
  output logic                                OUT_ldConflict,
  output logic [DC_BANKS-1:0]                 OUT_bankNce,
  output logic [DC_BANKS-1:0]                 OUT_bankNwe,
  output logic [DC_BANKS-1:0][DC_ROW_W-1:0]   OUT_bankAddr,
  output logic [DC_BANKS-1:0][31:0]           OUT_bankData,
  output logic [DC_BANKS-1:0][3:0]            OUT_bankWm,
  input  logic [DC_BANKS-1:0][31:0]           IN_bankRData
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  DCacheAcc_t           st_acc, sq_head;
  logic                 sq_empty, sq_full;
  logic                 mc_grant, sq_grant, mc_bank, hd_bank;
  arb_e                 arb;
  logic [SW-1:0]        starve_q, starve_d;
  logic [READ_LAT-1:0]  rbank_q, rbank_d;
  logic                 unused_head_we;

  assign st_acc = '{we: 1'b1, wm: IN_stWm, addr: IN_stAddr, data: IN_stData};

  dcache_store_queue #(.SQ_DEPTH(SQ_DEPTH)) u_sq (
    .clk_i         (clk),
    .rst_i         (rst),
    .enq_i         (IN_stValid),
    .enq_data_i    (st_acc),
    .deq_i         (sq_grant),
    .ld_valid_i    (IN_ldValid),
    .ld_addr_i     (IN_ldAddr),
    .head_o        (sq_head),
    .empty_o       (sq_empty),
    .full_o        (sq_full),
    .ld_conflict_o (OUT_ldConflict)
  );

  assign OUT_stStall    = sq_full;
  assign mc_bank        = acc_bank(IN_mcAddr);
  assign hd_bank        = acc_bank(sq_head.addr);
  assign unused_head_we = sq_head.we;

  // Grants are suppressed during reset so a discarded queue never writes.
  always_comb begin
    arb = ARB_IDLE;
    if (rst)                                   arb = ARB_IDLE;
    else if (sq_empty)                         arb = IN_mcValid ? ARB_MC_ONLY : ARB_IDLE;
    else if (!IN_mcValid || mc_bank != hd_bank) arb = ARB_PARALLEL;
    else if (starve_q < STARVE_MAX)            arb = ARB_MC_WINS;
    else                                       arb = ARB_SQ_FORCED;
  end

  always_comb begin
    mc_grant = (arb == ARB_MC_ONLY) || (arb == ARB_MC_WINS)
            || ((arb == ARB_PARALLEL) && IN_mcValid);
    sq_grant = (arb == ARB_PARALLEL) || (arb == ARB_SQ_FORCED);
    // Only a same-bank loss keeps the queue waiting; every other case
    // either dequeues the head or has an empty queue.
    starve_d = (arb == ARB_MC_WINS) ? starve_q + SW'(1) : '0;
    rbank_d  = (rbank_q << 1) | READ_LAT'(mc_grant && !IN_mcWe && mc_bank);
  end

  assign OUT_mcStall = IN_mcValid && !mc_grant;
  assign OUT_mcRData = IN_bankRData[rbank_q[READ_LAT-1]];

  always_comb begin
    OUT_bankNce  = '1;
    OUT_bankNwe  = '1;
    OUT_bankAddr = '0;
    OUT_bankData = '0;
    OUT_bankWm   = '0;
    if (mc_grant) begin
      OUT_bankNce[mc_bank]  = 1'b0;
      OUT_bankNwe[mc_bank]  = ~IN_mcWe;
      OUT_bankAddr[mc_bank] = acc_row(IN_mcAddr);
      OUT_bankData[mc_bank] = IN_mcData;
      OUT_bankWm[mc_bank]   = IN_mcWm;
    end
    if (sq_grant) begin
      OUT_bankNce[hd_bank]  = 1'b0;
      OUT_bankNwe[hd_bank]  = 1'b0;
      OUT_bankAddr[hd_bank] = acc_row(sq_head.addr);
      OUT_bankData[hd_bank] = sq_head.data;
      OUT_bankWm[hd_bank]   = sq_head.wm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rbank_q  <= '0;
    end else begin
      starve_q <= starve_d;
      rbank_q  <= rbank_d;
    end
  end

endmodule
